// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-item vending controller:
// FSM states, coin encoding and the coin-to-credit conversion.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CREDIT = 2'd1,
      ST_VEND   = 2'd2,
      ST_CHANGE = 2'd3
   } vend_state_e;

   typedef enum logic [1:0] {
      COIN_5  = 2'b00,
      COIN_10 = 2'b01,
      COIN_20 = 2'b10,
      COIN_50 = 2'b11
   } coin_e;

   localparam int COIN_VAL_W  = 8;
   localparam int CHANGE_UNIT = 5;

   function automatic logic [COIN_VAL_W-1:0] coin_value(coin_e c);
      logic [COIN_VAL_W-1:0] v;
      case (c)
         COIN_5:  v = 8'd5;
         COIN_10: v = 8'd10;
         COIN_20: v = 8'd20;
         COIN_50: v = 8'd50;
         default: v = 8'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters. Restock of an item overrides a same-cycle
// decrement of that item; a decrement of an empty item is ignored.
module vend_stock_bank
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS  = 4,
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         dec,
   input  logic [$clog2(NUM_ITEMS)-1:0] dec_item,
   input  logic                         restock,
   input  logic [$clog2(NUM_ITEMS)-1:0] restock_item,
   output logic [NUM_ITEMS-1:0]         empty
);

   localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(STOCK_INIT);

   logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
   logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

   always_comb begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
         stock_d[i] = stock_q[i];
         if (restock && (int'(restock_item) == i)) begin
            stock_d[i] = INIT_VAL;
         end else if (dec && (int'(dec_item) == i) && (stock_q[i] != '0)) begin
            stock_d[i] = stock_q[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (rst) begin
            stock_q[i] <= INIT_VAL;
         end else begin
            stock_q[i] <= stock_d[i];
         end
      end
   end

   always_comb begin
      empty = '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         empty[i] = (stock_q[i] == '0);
      end
   end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: coin credit, priced selection against stock,
// dispense handshake, change paid out as 5-unit coins, cancel and idle timeout.
module vend_ctrl_multi
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS   = 4,
   parameter int CREDIT_W    = 8,
   parameter int MAX_CREDIT  = 200,
   parameter int STOCK_W     = 4,
   parameter int STOCK_INIT  = 10,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          coin_valid,
   input  logic [1:0]                    coin_type,
   input  logic                          sel_valid,
   input  logic [$clog2(NUM_ITEMS)-1:0]  sel_item,
   input  logic                          cancel,
   input  logic [NUM_ITEMS*CREDIT_W-1:0] price_flat,
   input  logic                          restock,
   input  logic [$clog2(NUM_ITEMS)-1:0]  restock_item,
   output logic                          vend_valid,
   output logic [$clog2(NUM_ITEMS)-1:0]  vend_item,
   input  logic                          vend_ready,
   output logic                          chg_valid,
   input  logic                          chg_ready,
   output logic [CREDIT_W-1:0]           credit,
   output logic                          coin_reject,
   output logic                          sold_out,
   output logic                          insuff
);

   localparam int IDX_W = $clog2(NUM_ITEMS);
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CREDIT_W:0]   MAX_SUM  = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] UNIT     = CREDIT_W'(CHANGE_UNIT);
   localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   vend_state_e         state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [IDX_W-1:0]    vend_item_q, vend_item_d;
   logic                coin_reject_q, coin_reject_d;
   logic                sold_out_q, sold_out_d;
   logic                insuff_q, insuff_d;

   logic [CREDIT_W-1:0]  coin_val;
   logic [CREDIT_W:0]    credit_sum;
   logic [CREDIT_W-1:0]  sel_price;
   logic [NUM_ITEMS-1:0] stock_empty;
   logic                 in_accept, in_credit, sel_ok, sel_empty;
   logic                 coin_take, do_cancel, do_sel, vend_go;
   logic                 activity, timed_out, chg_fire;

   // Request decode; the coin loses to any same-cycle cancel or selection.
   always_comb begin
      coin_val   = CREDIT_W'(coin_value(coin_e'(coin_type)));
      credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
      sel_price  = price_flat[int'(sel_item)*CREDIT_W +: CREDIT_W];
      sel_ok     = (int'(sel_item) < NUM_ITEMS);
      sel_empty  = stock_empty[sel_item];
      in_accept  = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
      in_credit  = (state_q == ST_CREDIT);
      coin_take  = coin_valid && !cancel && !sel_valid && in_accept && (credit_sum <= MAX_SUM);
      do_cancel  = cancel && in_credit;
      do_sel     = sel_valid && !cancel && in_credit && sel_ok;
      vend_go    = do_sel && !sel_empty && (sel_price <= credit_q);
      activity   = coin_take || do_cancel || do_sel;
      timed_out  = in_credit && !activity && (tmr_q == TMR_LAST);
      chg_fire   = (state_q == ST_CHANGE) && chg_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (coin_take) state_d = ST_CREDIT;
         end
         ST_CREDIT: begin
            if (do_cancel || timed_out) begin
               state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end else if (vend_go) begin
               state_d = ST_VEND;
            end
         end
         ST_VEND: begin
            if (vend_ready) state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
         end
         ST_CHANGE: begin
            if (chg_ready && (credit_q <= UNIT)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      vend_valid = 1'b0;
      chg_valid  = 1'b0;
      case (state_q)
         ST_VEND:   vend_valid = 1'b1;
         ST_CHANGE: chg_valid  = 1'b1;
         default: ;
      endcase
   end

   // Credit only moves by guarded add, guarded subtract or one change unit.
   always_comb begin
      credit_d      = credit_q;
      tmr_d         = '0;
      vend_item_d   = vend_item_q;
      coin_reject_d = coin_valid && !coin_take;
      sold_out_d    = do_sel && sel_empty;
      insuff_d      = do_sel && !sel_empty && (sel_price > credit_q);
      if (coin_take) begin
         credit_d = credit_sum[CREDIT_W-1:0];
      end else if (vend_go) begin
         credit_d    = credit_q - sel_price;
         vend_item_d = sel_item;
      end else if (chg_fire) begin
         credit_d = (credit_q > UNIT) ? (credit_q - UNIT) : '0;
      end
      if (in_credit && !activity && !timed_out) begin
         tmr_d = tmr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credit_q      <= '0;
         tmr_q         <= '0;
         vend_item_q   <= '0;
         coin_reject_q <= 1'b0;
         sold_out_q    <= 1'b0;
         insuff_q      <= 1'b0;
      end else begin
         credit_q      <= credit_d;
         tmr_q         <= tmr_d;
         vend_item_q   <= vend_item_d;
         coin_reject_q <= coin_reject_d;
         sold_out_q    <= sold_out_d;
         insuff_q      <= insuff_d;
      end
   end

   vend_stock_bank #(
      .NUM_ITEMS  (NUM_ITEMS),
      .STOCK_W    (STOCK_W),
      .STOCK_INIT (STOCK_INIT)
   ) u_stock (
      .clk          (clk),
      .rst          (rst),
      .dec          (vend_go),
      .dec_item     (sel_item),
      .restock      (restock),
      .restock_item (restock_item),
      .empty        (stock_empty)
   );

   assign vend_item   = vend_item_q;
   assign credit      = credit_q;
   assign coin_reject = coin_reject_q;
   assign sold_out    = sold_out_q;
   assign insuff      = insuff_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scoreboard bench for vend_ctrl_multi: a transaction-level model predicts each
// cycle's outputs into a queue that a negedge monitor pops and compares.
module tb_vend_ctrl_multi;

   localparam int NUM_ITEMS   = 4;
   localparam int CREDIT_W    = 8;
   localparam int MAX_CREDIT  = 200;
   localparam int STOCK_W     = 4;
   localparam int STOCK_INIT  = 10;
   localparam int TIMEOUT_CYC = 1000;

   logic                          clk = 1'b0;
   logic                          rst;
   logic                          coin_valid;
   logic [1:0]                    coin_type;
   logic                          sel_valid;
   logic [1:0]                    sel_item;
   logic                          cancel;
   logic [NUM_ITEMS*CREDIT_W-1:0] price_flat;
   logic                          restock;
   logic [1:0]                    restock_item;
   logic                          vend_valid;
   logic [1:0]                    vend_item;
   logic                          vend_ready;
   logic                          chg_valid;
   logic                          chg_ready;
   logic [CREDIT_W-1:0]           credit;
   logic                          coin_reject;
   logic                          sold_out;
   logic                          insuff;

   vend_ctrl_multi #(
      .NUM_ITEMS(NUM_ITEMS), .CREDIT_W(CREDIT_W), .MAX_CREDIT(MAX_CREDIT),
      .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
      .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
      .price_flat(price_flat), .restock(restock), .restock_item(restock_item),
      .vend_valid(vend_valid), .vend_item(vend_item), .vend_ready(vend_ready),
      .chg_valid(chg_valid), .chg_ready(chg_ready), .credit(credit),
      .coin_reject(coin_reject), .sold_out(sold_out), .insuff(insuff)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int cyc;
      int credit;
      bit vv;
      bit cv;
      int item;
      bit rej;
      bit so;
      bit ins;
   } snap_t;

   snap_t exp_q[$];

   // Reference model: credit as an integer, two flags for "dispensing" and
   // "paying change", an idle-cycle count and an integer stock per item.
   int m_credit;
   bit m_vend;
   bit m_refund;
   int m_item;
   int m_idle;
   int m_stock[NUM_ITEMS];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int coin_rs(input logic [1:0] t);
      case (t)
         2'd0: return 5;
         2'd1: return 10;
         2'd2: return 20;
         default: return 50;
      endcase
   endfunction

   function automatic int price_of(input int i);
      return int'(price_flat[i*CREDIT_W +: CREDIT_W]);
   endfunction

   // Apply current inputs to the model, queue the predicted next-cycle view, advance one clock.
   task automatic tick();
      int c0, pr;
      bit vend0, ref0, accm, incred, act, rj, so, ins;
      snap_t s;
      rj = 0; so = 0; ins = 0;
      if (rst) begin
         m_credit = 0; m_vend = 0; m_refund = 0; m_item = 0; m_idle = 0;
         for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = STOCK_INIT;
      end else begin
         c0 = m_credit; vend0 = m_vend; ref0 = m_refund;
         accm = !vend0 && !ref0;
         incred = accm && (c0 > 0);
         act = 0;
         if (coin_valid) begin
            if (!cancel && !sel_valid && accm && (c0 + coin_rs(coin_type) <= MAX_CREDIT)) begin
               m_credit = c0 + coin_rs(coin_type);
               act = 1;
            end else begin
               rj = 1;
            end
         end
         if (incred && cancel) begin
            m_refund = 1; act = 1;
         end else if (incred && sel_valid) begin
            act = 1;
            pr = price_of(int'(sel_item));
            if (m_stock[sel_item] == 0) so = 1;
            else if (pr > c0) ins = 1;
            else begin
               m_credit = c0 - pr;
               m_stock[sel_item] = m_stock[sel_item] - 1;
               m_item = int'(sel_item);
               m_vend = 1;
            end
         end
         if (vend0 && vend_ready) begin
            m_vend = 0;
            m_refund = (m_credit > 0);
         end
         if (ref0 && chg_ready) begin
            m_credit = m_credit - 5;
            if (m_credit <= 0) begin m_credit = 0; m_refund = 0; end
         end
         if (incred && !act) begin
            m_idle++;
            if (m_idle >= TIMEOUT_CYC) begin m_idle = 0; m_refund = 1; end
         end else begin
            m_idle = 0;
         end
         if (restock) m_stock[restock_item] = STOCK_INIT;
      end
      s = '{cyc + 1, m_credit, m_vend, m_refund, m_item, rj, so, ins};
      exp_q.push_back(s);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      snap_t s;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         s = exp_q.pop_front();
         chk("sb_credit", int'(credit), s.credit);
         chk("sb_vend_valid", int'(vend_valid), int'(s.vv));
         chk("sb_chg_valid", int'(chg_valid), int'(s.cv));
         chk("sb_coin_reject", int'(coin_reject), int'(s.rej));
         chk("sb_sold_out", int'(sold_out), int'(s.so));
         chk("sb_insuff", int'(insuff), int'(s.ins));
         if (s.vv) chk("sb_vend_item", int'(vend_item), s.item);
      end
   end

   task automatic idle_inputs();
      coin_valid = 0; coin_type = 0; sel_valid = 0; sel_item = 0; cancel = 0;
      restock = 0; restock_item = 0; vend_ready = 0; chg_ready = 0;
   endtask

   task automatic set_price(input int i, input int v);
      price_flat[i*CREDIT_W +: CREDIT_W] = CREDIT_W'(v);
   endtask

   task automatic coin(input int t);
      coin_valid = 1; coin_type = 2'(t); tick(); coin_valid = 0;
   endtask

   task automatic sel(input int i);
      sel_valid = 1; sel_item = 2'(i); tick(); sel_valid = 0;
   endtask

   task automatic vend_accept();
      vend_ready = 1; tick(); vend_ready = 0;
   endtask

   task automatic drain(output int n);
      n = 0;
      chg_ready = 1;
      for (int k = 0; k < 60 && chg_valid; k++) begin
         n++;
         tick();
      end
      chg_ready = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1;
      idle_inputs();
      price_flat = '0;
      tick(); tick();
      rst = 0;
      chk("reset_credit", int'(credit), 0);
      chk("reset_vend_valid", int'(vend_valid), 0);
      chk("reset_chg_valid", int'(chg_valid), 0);

      // Exact-change purchase
      set_price(0, 15);
      coin(1); coin(0);
      chk("t1_credit15", int'(credit), 15);
      sel(0);
      chk("t1_vend_valid", int'(vend_valid), 1);
      chk("t1_vend_item", int'(vend_item), 0);
      chk("t1_credit0", int'(credit), 0);
      vend_accept();
      chk("t1_back_idle", int'(vend_valid | chg_valid), 0);

      // Overpay, change with a stalled hopper
      coin(3); coin(3);
      sel(0);
      chk("t2_credit85", int'(credit), 85);
      vend_accept();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t2_stall_chg_valid", int'(chg_valid), 1);
      end
      chk("t2_stall_credit", int'(credit), 85);
      drain(n);
      chk("t2_chg_count", n, 17);
      chk("t2_final_credit", int'(credit), 0);

      // MAX_CREDIT guard and coin/selection collision
      set_price(2, 100);
      coin(3); coin(3); coin(3); coin(2); coin(2); coin(0);
      chk("t3_credit195", int'(credit), 195);
      coin(1);
      chk("t3_over_reject", int'(coin_reject), 1);
      chk("t3_credit_kept", int'(credit), 195);
      coin_valid = 1; coin_type = 0; sel_valid = 1; sel_item = 2;
      tick();
      coin_valid = 0; sel_valid = 0;
      chk("t3_collide_reject", int'(coin_reject), 1);
      chk("t3_collide_vend", int'(vend_valid), 1);
      chk("t3_collide_credit", int'(credit), 95);
      vend_accept();
      drain(n);
      chk("t3_chg_count", n, 19);

      // Sell out item 1, then restock
      set_price(1, 5);
      for (int k = 0; k < STOCK_INIT; k++) begin
         coin(0); sel(1); vend_accept();
      end
      coin(1); sel(1);
      chk("t4_sold_out", int'(sold_out), 1);
      chk("t4_credit_kept", int'(credit), 10);
      restock = 1; restock_item = 1; tick(); restock = 0;
      sel(1);
      chk("t4_restock_vend", int'(vend_valid), 1);
      chk("t4_restock_credit", int'(credit), 5);
      vend_accept();
      drain(n);
      chk("t4_chg_count", n, 1);

      // Inactivity timeout and cancel
      coin(2);
      repeat (TIMEOUT_CYC - 1) tick();
      chk("t5_before_timeout", int'(chg_valid), 0);
      tick();
      chk("t5_timeout_chg", int'(chg_valid), 1);
      drain(n);
      chk("t5_timeout_count", n, 4);
      coin(1);
      cancel = 1; tick(); cancel = 0;
      chk("t5_cancel_chg", int'(chg_valid), 1);
      drain(n);
      chk("t5_cancel_count", n, 2);

      // Reset during VEND and during CHANGE
      set_price(3, 5);
      coin(0); sel(3);
      chk("t6_in_vend", int'(vend_valid), 1);
      rst = 1; tick(); rst = 0;
      chk("t6_vend_rst_valid", int'(vend_valid), 0);
      chk("t6_vend_rst_credit", int'(credit), 0);
      coin(3); sel(3); vend_accept();
      chg_ready = 1; tick(); chg_ready = 0;
      chk("t6_mid_change_credit", int'(credit), 40);
      rst = 1; tick(); rst = 0;
      chk("t6_chg_rst_valid", int'(chg_valid), 0);
      chk("t6_chg_rst_credit", int'(credit), 0);

      // Randomised traffic against the model
      for (int k = 0; k < 4000; k++) begin
         if (k % 500 == 0) begin
            for (int i = 0; i < NUM_ITEMS; i++) set_price(i, int'($urandom_range(0, 12)) * 5);
         end
         rst          = ($urandom_range(0, 199) == 0);
         coin_valid   = ($urandom_range(0, 9) < 4);
         coin_type    = 2'($urandom_range(0, 3));
         sel_valid    = ($urandom_range(0, 9) < 2);
         sel_item     = 2'($urandom_range(0, 3));
         cancel       = ($urandom_range(0, 49) == 0);
         restock      = ($urandom_range(0, 59) == 0);
         restock_item = 2'($urandom_range(0, 3));
         vend_ready   = ($urandom_range(0, 1) == 1);
         chg_ready    = ($urandom_range(0, 9) < 7);
         tick();
      end
      rst = 0;
      idle_inputs();
      tick(); tick();

      @(negedge clk);
      #1;
      chk("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
